// File: rtl/bus_slot_scheduler_pkg.sv
// Shared constants, types and helpers for the bus slot scheduler: period length,
// VIA strobe phases, DMA FSM states and the RAM address width.
package bus_slot_scheduler_pkg;

   localparam int PERIOD_DEFAULT = 50;
   localparam int RAM_AW         = 13;
   localparam int NUM_VIA        = 4;

   localparam logic [5:0] VIA_PHASES [NUM_VIA] = '{6'd9, 6'd17, 6'd25, 6'd33};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dma_state_t;

   function automatic logic is_via_phase(input logic [5:0] p);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_VIA; i++) begin
         if (p == VIA_PHASES[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/bus_slot_scheduler_phase_gen.sv
// Phase counter for one CPU bus cycle plus the registered CPU, memory and VIA
// strobes, each decoded from the next phase so it lines up with the phase output.
module bus_slot_scheduler_phase_gen
   import bus_slot_scheduler_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [5:0] phase,
   output logic       cpu_clken,
   output logic       cpu_clken1,
   output logic       via_clken
);

   logic [5:0] phase_nxt;

   always_comb begin
      phase_nxt = (phase == 6'(PERIOD - 1)) ? 6'd0 : phase + 6'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase      <= 6'd0;
         cpu_clken  <= 1'b0;
         cpu_clken1 <= 1'b0;
         via_clken  <= 1'b0;
      end else begin
         phase      <= phase_nxt;
         cpu_clken  <= (phase_nxt == 6'd0);
         cpu_clken1 <= (phase_nxt == 6'd1);
         via_clken  <= is_via_phase(phase_nxt);
      end
   end

endmodule

// File: rtl/bus_slot_scheduler.sv
// Shares one synchronous RAM port between the CPU (fixed slot at phase 1) and a
// DMA requester that may start an access only inside the DMA_FIRST..DMA_LAST window.
module bus_slot_scheduler
   import bus_slot_scheduler_pkg::*;
#(
   parameter int PERIOD    = PERIOD_DEFAULT,
   parameter int DMA_FIRST = 4,
   parameter int DMA_LAST  = 44
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              cpu_clken,
   output logic              cpu_clken1,
   output logic              via_clken,
   output logic [5:0]        phase,
   input  logic              cpu_ram_sel,
   input  logic              cpu_we,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [RAM_AW-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   output logic              dma_ack,
   output logic [7:0]        dma_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   dma_state_t state;
   logic       start_win;
   logic [7:0] dma_rdata_q;
   logic       cpu_rd_pend;

   bus_slot_scheduler_phase_gen #(.PERIOD(PERIOD)) u_phase_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .phase      (phase),
      .cpu_clken  (cpu_clken),
      .cpu_clken1 (cpu_clken1),
      .via_clken  (via_clken)
   );

   // The window is tested one phase early: the ACCESS cycle itself must land in DMA_FIRST..DMA_LAST.
   assign start_win = (phase >= 6'(DMA_FIRST - 1)) && (phase <= 6'(DMA_LAST - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         dma_ack     <= 1'b0;
         dma_rdata_q <= 8'd0;
      end else begin
         dma_ack <= 1'b0;
         case (state)
            IDLE:    if (dma_req && start_win) state <= ACCESS;
            ACCESS: begin
               state   <= RESP;
               dma_ack <= 1'b1;
            end
            RESP: begin
               state <= IDLE;
               if (!dma_we) dma_rdata_q <= ram_rdata;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM data arrives during RESP, so it is passed straight through while dma_ack is high.
   assign dma_rdata = (dma_ack && !dma_we) ? ram_rdata : dma_rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_rd_pend <= 1'b0;
         cpu_rdata   <= 8'd0;
      end else begin
         if (phase == 6'd1) cpu_rd_pend <= cpu_ram_sel && !cpu_we;
         if (phase == 6'd2 && cpu_rd_pend) cpu_rdata <= ram_rdata;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = 8'd0;
      if (phase == 6'd1) begin
         ram_en    = cpu_ram_sel;
         ram_we    = cpu_we & cpu_ram_sel;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (state == ACCESS) begin
         ram_en    = 1'b1;
         ram_we    = dma_we;
         ram_addr  = dma_addr;
         ram_wdata = dma_wdata;
      end
   end

endmodule
